// File: rtl/test_i9621.sv
// test_i9621: three-flop state pipeline with a combinational golden output,
// plus a sticky mode flag that inverts the output once the input pattern
// sequence 101 -> 010 -> 111 has been seen on consecutive clock edges.
module test_i9621 (
    input  logic CK,
    input  logic reset,
    input  logic N0,
    input  logic N1,
    input  logic N2,
    output logic Y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2
    } seq_t;

    logic       a;
    logic       b;
    logic       c;
    logic [2:0] pattern;
    logic       q0;
    logic       q1;
    logic       q2;
    logic       flag;
    logic       golden;
    seq_t       seq_state;

    assign a       = N0;
    assign b       = N1;
    assign c       = N2;
    assign pattern = {N0, N1, N2};

    // Pipeline registers, sequence detector and sticky flag all advance together on each edge
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            q0        <= 1'b0;
            q1        <= 1'b0;
            q2        <= 1'b0;
            flag      <= 1'b0;
            seq_state <= IDLE;
        end else begin
            q0 <= a ^ b;
            q1 <= q0 & ~c;
            q2 <= q1 | (a & c);

            case (seq_state)
                IDLE: begin
                    if (pattern == 3'b101) seq_state <= S1;
                    else                   seq_state <= IDLE;
                end
                S1: begin
                    if (pattern == 3'b010)      seq_state <= S2;
                    else if (pattern == 3'b101) seq_state <= S1;
                    else                        seq_state <= IDLE;
                end
                S2: begin
                    if (pattern == 3'b111) begin
                        flag      <= 1'b1;
                        seq_state <= IDLE;
                    end else if (pattern == 3'b101) begin
                        seq_state <= S1;
                    end else begin
                        seq_state <= IDLE;
                    end
                end
                default: seq_state <= IDLE;
            endcase
        end
    end

    // Output stays combinational so input changes reach Y with no latency, even during reset
    always_comb begin
        golden = (q2 ^ c) | (q0 & b);
        Y      = golden ^ flag;
    end

endmodule

// File: tb/tb_test_i9621.sv
// tb_test_i9621: directed-vector bench for test_i9621. The stimulus process
// pushes each expected Y into a queue; a separate monitor pops and compares
// whenever a sample is presented.
module tb_test_i9621;

    logic CK;
    logic reset;
    logic N0;
    logic N1;
    logic N2;
    logic Y;

    typedef struct {
        logic  exp;
        string name;
    } expect_t;

    expect_t exp_q[$];
    event    sample_ev;
    int      compared;
    int      mismatched;

    // Reference state used only for the random segment
    logic       m_q0;
    logic       m_q1;
    logic       m_q2;
    logic       m_flag;
    logic [1:0] m_seq;

    test_i9621 dut (
        .CK    (CK),
        .reset (reset),
        .N0    (N0),
        .N1    (N1),
        .N2    (N2),
        .Y     (Y)
    );

    // Free-running clock, period 10
    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Global time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got no summary, required finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic model_y(input logic [2:0] p);
        logic gv;
        gv = (m_q2 ^ p[0]) | (m_q0 & p[1]);
        return gv ^ m_flag;
    endfunction

    task automatic model_reset();
        m_q0   = 1'b0;
        m_q1   = 1'b0;
        m_q2   = 1'b0;
        m_flag = 1'b0;
        m_seq  = 2'd0;
    endtask

    task automatic model_edge(input logic [2:0] p);
        logic n0;
        logic n1;
        logic n2;
        n0 = p[2] ^ p[1];
        n1 = m_q0 & ~p[0];
        n2 = m_q1 | (p[2] & p[0]);
        m_q0 = n0;
        m_q1 = n1;
        m_q2 = n2;
        case (m_seq)
            2'd0: m_seq = (p == 3'b101) ? 2'd1 : 2'd0;
            2'd1: m_seq = (p == 3'b010) ? 2'd2 : (p == 3'b101) ? 2'd1 : 2'd0;
            2'd2: begin
                if (p == 3'b111) begin
                    m_flag = 1'b1;
                    m_seq  = 2'd0;
                end else begin
                    m_seq = (p == 3'b101) ? 2'd1 : 2'd0;
                end
            end
            default: m_seq = 2'd0;
        endcase
    endtask

    task automatic push_expect(input logic e, input string name);
        expect_t item;
        item.exp  = e;
        item.name = name;
        exp_q.push_back(item);
        ->sample_ev;
    endtask

    // Drive one pattern at the falling edge, check Y before the next rising edge
    task automatic apply_stimulus(input logic [2:0] p, input bit use_model,
                                  input logic e, input string name);
        logic ev;
        @(negedge CK);
        {N0, N1, N2} = p;
        #1;
        ev = use_model ? model_y(p) : e;
        push_expect(ev, name);
        @(posedge CK);
        if (reset) model_edge(p);
    endtask

    task automatic do_reset();
        @(negedge CK);
        reset = 1'b0;
        {N0, N1, N2} = 3'b000;
        model_reset();
        @(negedge CK);
        reset = 1'b1;
    endtask

    task automatic check_output(input expect_t item);
        compared++;
        if (Y !== item.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: Y=%b expected %b at %0t", item.name, Y, item.exp, $time);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a sample is presented
    initial begin
        expect_t item;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard: sample with empty queue, got 0 entries, required 1");
            end else begin
                item = exp_q.pop_front();
                check_output(item);
            end
        end
    end

    initial begin
        logic [2:0] p;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        {N0, N1, N2} = 3'b000;
        model_reset();

        // Reset held: Y follows N2 for every pattern, clock has no effect
        for (int i = 0; i < 8; i++) begin
            p = i[2:0];
            apply_stimulus(p, 1'b0, p[0], "reset_sweep");
        end

        // Pipeline propagation
        do_reset();
        apply_stimulus(3'b100, 1'b0, 1'b0, "pipe_pre");
        apply_stimulus(3'b000, 1'b0, 1'b0, "pipe_edge1");
        apply_stimulus(3'b000, 1'b0, 1'b0, "pipe_edge2");
        apply_stimulus(3'b000, 1'b0, 1'b1, "pipe_edge3");
        apply_stimulus(3'b000, 1'b0, 1'b0, "pipe_edge4");

        // Direct combinational path from clean state
        do_reset();
        apply_stimulus(3'b011, 1'b0, 1'b1, "direct_path");

        // Broken sequence: flag must stay clear
        do_reset();
        apply_stimulus(3'b101, 1'b0, 1'b1, "broken_101");
        apply_stimulus(3'b010, 1'b0, 1'b1, "broken_010");
        apply_stimulus(3'b110, 1'b0, 1'b1, "broken_110");
        apply_stimulus(3'b111, 1'b0, 1'b0, "broken_111");
        apply_stimulus(3'b111, 1'b0, 1'b0, "broken_hold");

        // Trigger sequence sets the sticky flag
        do_reset();
        apply_stimulus(3'b101, 1'b0, 1'b1, "trig_101");
        apply_stimulus(3'b010, 1'b0, 1'b1, "trig_010");
        apply_stimulus(3'b111, 1'b0, 1'b1, "trig_111");
        apply_stimulus(3'b111, 1'b0, 1'b1, "trig_hold1");
        apply_stimulus(3'b111, 1'b0, 1'b1, "trig_hold2");

        // Random cycles with flag set: Y is the inverted golden output
        for (int i = 0; i < 20; i++) begin
            p = 3'($urandom_range(0, 7));
            apply_stimulus(p, 1'b1, 1'b0, "sticky_random");
        end

        // Mid-cycle reset clears flag immediately; Y follows N2
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        push_expect(N2, "midreset_now");
        apply_stimulus(3'b110, 1'b0, 1'b0, "midreset_110");
        apply_stimulus(3'b011, 1'b0, 1'b1, "midreset_011");

        // Released with flag cleared: 111 from zero state gives Y=1
        @(negedge CK);
        reset = 1'b1;
        apply_stimulus(3'b111, 1'b0, 1'b1, "after_reset_111");

        @(negedge CK);
        #2;
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
